// File: rtl/jtag_debug_scan_master.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_debug_scan_master
//  Brief    : Host-side virtual-JTAG scan initiator: IR + DR scan, tdo capture,
//             valid/ready response.
//  Revision : 1.0  initial release
// ============================================================================
module jtag_debug_scan_master #(
    parameter int DR_WIDTH   = 38,
    parameter int IR_WIDTH   = 2,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RESP = 3'd6
    } state_t;

    localparam int                 c_BIT_W    = $clog2(DR_WIDTH + 1);
    localparam logic [7:0]         c_DIV_LAST = 8'(TCK_DIV - 1);
    localparam logic [3:0]         c_RTI_LAST = 4'(RTI_CYCLES - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DR_WIDTH - 1);

    state_t                r_state;
    logic [7:0]            r_div_cnt;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [3:0]            r_per_cnt;
    logic [DR_WIDTH-1:0]   r_sr;
    logic                  r_tck;
    logic                  r_tdi;
    logic [IR_WIDTH-1:0]   r_ir_in;
    logic                  r_uir;
    logic                  r_cdr;
    logic                  r_sdr;
    logic                  r_udr;
    logic                  r_rti;
    logic                  r_cmd_ready;
    logic                  r_busy;
    logic                  r_rsp_valid;
    logic [DR_WIDTH-1:0]   r_rsp_dr;
    logic [IR_WIDTH-1:0]   r_rsp_ir_out;

    logic w_run;
    logic w_tick;
    logic w_rise;
    logic w_fall;

    // tck only runs between accept and the final RTI fall
    assign w_run  = (r_state != ST_IDLE) && (r_state != ST_RESP);
    assign w_tick = w_run && (r_div_cnt == c_DIV_LAST);
    assign w_rise = w_tick && !r_tck;
    assign w_fall = w_tick && r_tck;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_per_cnt    <= '0;
            r_sr         <= '0;
            r_tck        <= 1'b0;
            r_tdi        <= 1'b0;
            r_ir_in      <= '0;
            r_uir        <= 1'b0;
            r_cdr        <= 1'b0;
            r_sdr        <= 1'b0;
            r_udr        <= 1'b0;
            r_rti        <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_dr     <= '0;
            r_rsp_ir_out <= '0;
        end else begin
            if (w_run) begin
                if (w_tick) begin
                    r_div_cnt <= '0;
                    r_tck     <= ~r_tck;
                end else begin
                    r_div_cnt <= r_div_cnt + 1'b1;
                end
            end else begin
                r_div_cnt <= '0;
                r_tck     <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_sr        <= cmd_dr;
                        r_ir_in     <= cmd_ir;
                        r_uir       <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_per_cnt   <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_UIR;
                    end
                end
                ST_UIR: begin
                    if (w_rise) begin
                        r_rsp_ir_out <= vji_ir_out;
                    end
                    if (w_fall) begin
                        r_uir   <= 1'b0;
                        r_cdr   <= 1'b1;
                        r_state <= ST_CDR;
                    end
                end
                ST_CDR: begin
                    if (w_fall) begin
                        r_cdr   <= 1'b0;
                        r_sdr   <= 1'b1;
                        r_tdi   <= r_sr[0];
                        r_state <= ST_SDR;
                    end
                end
                ST_SDR: begin
                    if (w_rise) begin
                        r_sr <= {vji_tdo, r_sr[DR_WIDTH-1:1]};
                    end
                    // the rise has already shifted, so r_sr[0] is the next bit out
                    if (w_fall) begin
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_sdr   <= 1'b0;
                            r_tdi   <= 1'b0;
                            r_udr   <= 1'b1;
                            r_state <= ST_UDR;
                        end else begin
                            r_tdi     <= r_sr[0];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_UDR: begin
                    if (w_fall) begin
                        r_udr     <= 1'b0;
                        r_rti     <= 1'b1;
                        r_per_cnt <= '0;
                        r_state   <= ST_RTI;
                    end
                end
                ST_RTI: begin
                    if (w_fall) begin
                        if (r_per_cnt == c_RTI_LAST) begin
                            r_rti       <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_dr    <= r_sr;
                            r_state     <= ST_RESP;
                        end else begin
                            r_per_cnt <= r_per_cnt + 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (r_rsp_valid && rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_dr     = r_rsp_dr;
    assign rsp_ir_out = r_rsp_ir_out;
    assign busy       = r_busy;
    assign vji_tck    = r_tck;
    assign vji_tdi    = r_tdi;
    assign vji_ir_in  = r_ir_in;
    assign vji_uir    = r_uir;
    assign vji_cdr    = r_cdr;
    assign vji_sdr    = r_sdr;
    assign vji_udr    = r_udr;
    assign vji_rti    = r_rti;

endmodule
`default_nettype wire

// File: tb/tb_jtag_debug_scan_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtag_debug_scan_master
//  Brief    : Self-checking bench with a loopback virtual-JTAG slave model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtag_debug_scan_master;

    localparam int W = 38;

    typedef struct {
        logic [1:0]   ir;
        logic [W-1:0] dr;
        logic [W-1:0] cap;
        logic [1:0]   irout;
        logic [W-1:0] exp_rsp;
        logic [W-1:0] exp_rx;
        logic [1:0]   exp_irout;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // ---------------- DUT 1: default parameters ----------------
    logic         cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [1:0]   cmd_ir, rsp_ir_out, ir_in, ir_out;
    logic [W-1:0] cmd_dr, rsp_dr;
    logic         tck, tdi, tdo, uir, cdr, sdr, udr, rti;

    jtag_debug_scan_master dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .busy(busy), .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo),
        .vji_ir_in(ir_in), .vji_ir_out(ir_out),
        .vji_uir(uir), .vji_cdr(cdr), .vji_sdr(sdr), .vji_udr(udr), .vji_rti(rti)
    );

    // ---------------- DUT 2: TCK_DIV=1, RTI_CYCLES=1 ----------------
    logic         cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2, busy2;
    logic [1:0]   cmd_ir2, rsp_ir_out2, ir_in2, ir_out2;
    logic [W-1:0] cmd_dr2, rsp_dr2;
    logic         tck2, tdi2, tdo2, uir2, cdr2, sdr2, udr2, rti2;

    jtag_debug_scan_master #(.TCK_DIV(1), .RTI_CYCLES(1)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_ir(cmd_ir2), .cmd_dr(cmd_dr2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_dr(rsp_dr2), .rsp_ir_out(rsp_ir_out2),
        .busy(busy2), .vji_tck(tck2), .vji_tdi(tdi2), .vji_tdo(tdo2),
        .vji_ir_in(ir_in2), .vji_ir_out(ir_out2),
        .vji_uir(uir2), .vji_cdr(cdr2), .vji_sdr(sdr2), .vji_udr(udr2), .vji_rti(rti2)
    );

    // ---------------- loopback slaves: capture at CDR, shift on rises ----------------
    logic [W-1:0] s1_sr, s1_rx, s1_cap;
    always @(posedge tck) begin
        if (cdr)      s1_sr <= s1_cap;
        else if (sdr) s1_sr <= {tdi, s1_sr[W-1:1]};
        else if (udr) s1_rx <= s1_sr;
    end
    assign tdo = s1_sr[0];

    logic [W-1:0] s2_sr, s2_rx, s2_cap;
    always @(posedge tck2) begin
        if (cdr2)      s2_sr <= s2_cap;
        else if (sdr2) s2_sr <= {tdi2, s2_sr[W-1:1]};
        else if (udr2) s2_rx <= s2_sr;
    end
    assign tdo2 = s2_sr[0];

    // ---------------- monitors ----------------
    logic [4:0] strb;
    assign strb = {uir, cdr, sdr, udr, rti};
    logic [4:0] strb_log[$];
    int sdr_rises;
    always @(posedge tck) begin
        strb_log.push_back(strb);
        if (sdr) sdr_rises++;
    end

    time t_last2 = 0;
    time period2 = 0;
    always @(posedge tck2) begin
        if (t_last2 != 0) period2 = $time - t_last2;
        t_last2 = $time;
    end

    // strobes/tdi/ir_in may only move on a tck fall or on the accept edge
    logic       mon_en = 1'b0;
    logic [7:0] prev_vec = '0;
    logic       prev_tck = 1'b0;
    logic [7:0] cur_vec;
    assign cur_vec = {strb, tdi, ir_in};
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (cur_vec != prev_vec && !(prev_tck && !tck) &&
                !(prev_vec[7:3] == 5'b0 && strb == 5'b10000)) begin
                errors++;
                $display("FAIL strobe_timing: got %b was %b (tck %b->%b)", cur_vec, prev_vec, prev_tck, tck);
            end
            checks++;
            if ((busy && !rsp_valid) ? !$onehot(strb) : (strb != 5'b0)) begin
                errors++;
                $display("FAIL strobe_onehot: got strobes %b busy %b rsp_valid %b", strb, busy, rsp_valid);
            end
        end
        prev_vec = cur_vec;
        prev_tck = tck;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // reference: loopback slave returns its capture word, receives the command word
    function automatic vec_t model(input logic [1:0] ir, input logic [W-1:0] dr,
                                   input logic [W-1:0] cap, input logic [1:0] irout);
        vec_t v;
        v.ir = ir; v.dr = dr; v.cap = cap; v.irout = irout;
        v.exp_rsp = cap; v.exp_rx = dr; v.exp_irout = irout;
        return v;
    endfunction

    function automatic logic [W-1:0] rnd38();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    task automatic start_cmd(input logic [1:0] ir, input logic [W-1:0] dr);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", {63'b0, cmd_ready}, 64'd1);
        cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1;
        strb_log.delete();
        sdr_rises = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_dr = rnd38();
        cmd_ir = ~ir;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_scan(input vec_t v, input int cyc, input int exp_cyc, input int rti_n);
        logic [4:0] exp_log[$];
        int bad = -1;
        chk("latency", 64'(cyc), 64'(exp_cyc));
        chk("rsp_dr", 64'(rsp_dr), 64'(v.exp_rsp));
        chk("rsp_ir_out", 64'(rsp_ir_out), 64'(v.exp_irout));
        chk("slave_rx", 64'(s1_rx), 64'(v.exp_rx));
        chk("ir_in", 64'(ir_in), 64'(v.ir));
        chk("sdr_rises", 64'(sdr_rises), 64'(W));
        exp_log.push_back(5'b10000);
        exp_log.push_back(5'b01000);
        for (int i = 0; i < W; i++) exp_log.push_back(5'b00100);
        exp_log.push_back(5'b00010);
        for (int i = 0; i < rti_n; i++) exp_log.push_back(5'b00001);
        for (int i = 0; i < exp_log.size(); i++)
            if (bad < 0 && (i >= strb_log.size() || strb_log[i] !== exp_log[i])) bad = i;
        if (bad < 0 && strb_log.size() != exp_log.size()) bad = exp_log.size();
        chk("strobe_sequence_first_bad_index", 64'(bad), 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    task automatic release_rsp(input logic [1:0] ir);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_after_ack", {63'b0, rsp_valid}, 64'd0);
        chk("cmd_ready_after_ack", {63'b0, cmd_ready}, 64'd1);
        chk("ir_in_hold", 64'(ir_in), 64'(ir));
    endtask

    task automatic run_scan(input vec_t v);
        int cyc;
        s1_cap = v.cap;
        ir_out = v.irout;
        start_cmd(v.ir, v.dr);
        wait_rsp(cyc);
        check_scan(v, cyc, (3 + W + 2) * 2 * 2, 2);
        release_rsp(v.ir);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    vec_t tbl[3];

    initial begin
        vec_t v;
        vec_t v2;
        int   cyc;
        int   n;
        logic stable_ok;
        logic [W-1:0] held;

        tbl[0] = '{2'b01, 38'h2A_5555_AAAA, 38'h3F_0000_1234, 2'b10,
                   38'h3F_0000_1234, 38'h2A_5555_AAAA, 2'b10};
        tbl[1] = '{2'b11, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 2'b01,
                   38'h3F_FFFF_FFFF, 38'h00_0000_0000, 2'b01};
        tbl[2] = '{2'b10, 38'h3F_FFFF_FFFF, 38'h00_0000_0001, 2'b11,
                   38'h00_0000_0001, 38'h3F_FFFF_FFFF, 2'b11};

        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; rsp_ready = 1'b0; ir_out = '0;
        cmd_valid2 = 1'b0; cmd_ir2 = '0; cmd_dr2 = '0; rsp_ready2 = 1'b0; ir_out2 = '0;
        s1_cap = '0; s2_cap = '0; sdr_rises = 0;

        // reset state, during and after reset
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({tck, tdi, strb, rsp_valid, busy, cmd_ready}), 64'b0000000001);
        chk("reset_data", 64'({ir_in, rsp_dr, rsp_ir_out}), 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_ctrl", 64'({tck, tdi, strb, rsp_valid, busy, cmd_ready}), 64'b0000000001);
        mon_en = 1'b1;

        // rsp_ready with nothing pending
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rsp_ready = 1'b0;
        chk("idle_rsp_ready_noop", 64'({rsp_valid, busy, cmd_ready}), 64'b001);

        for (int i = 0; i < 3; i++) run_scan(tbl[i]);

        for (int i = 0; i < 5; i++) begin
            v = model(2'($urandom_range(0, 3)), rnd38(), rnd38(), 2'($urandom_range(0, 3)));
            run_scan(v);
        end

        // backpressure with a command attempted while the response is pending
        v = model(2'b01, rnd38(), rnd38(), 2'b10);
        s1_cap = v.cap; ir_out = v.irout;
        start_cmd(v.ir, v.dr);
        wait_rsp(cyc);
        check_scan(v, cyc, 172, 2);
        held = rsp_dr;
        stable_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cmd_valid = (i >= 5 && i < 12);
            cmd_ir = 2'b11; cmd_dr = rnd38();
            if (!rsp_valid || rsp_dr !== held || cmd_ready || !busy || uir) stable_ok = 1'b0;
        end
        chk("backpressure_stable", {63'b0, stable_ok}, 64'd1);
        v2 = model(2'b11, rnd38(), rnd38(), 2'b01);
        cmd_valid = 1'b1; cmd_ir = v2.ir; cmd_dr = v2.dr;
        s1_cap = v2.cap; ir_out = v2.irout;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("handshake_to_idle", 64'({rsp_valid, cmd_ready, uir}), 64'b010);
        strb_log.delete();
        sdr_rises = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("accept_one_cycle_later", 64'({busy, uir, cmd_ready, ir_in}), 64'({1'b1, 1'b1, 1'b0, v2.ir}));
        cmd_dr = rnd38();
        wait_rsp(cyc);
        check_scan(v2, cyc, 172, 2);
        release_rsp(v2.ir);

        // reset in the middle of the data shift
        v = model(2'b10, rnd38(), rnd38(), 2'b01);
        s1_cap = v.cap; ir_out = v.irout;
        start_cmd(v.ir, v.dr);
        n = 0;
        while (sdr_rises < 10 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_10th_shift", 64'(sdr_rises), 64'd10);
        mon_en = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("midscan_reset_drop", 64'({tck, sdr, strb, tdi, busy, rsp_valid, cmd_ready}), 64'b00000000001);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) n++;
        end
        chk("no_response_after_reset", 64'(n), 64'd0);
        mon_en = 1'b1;
        run_scan(model(2'b01, rnd38(), rnd38(), 2'b11));

        // fast parameter set on the second instance
        s2_cap = rnd38();
        v = model(2'b01, rnd38(), s2_cap, 2'b00);
        @(negedge clk);
        cmd_valid2 = 1'b1; cmd_ir2 = v.ir; cmd_dr2 = v.dr;
        @(posedge clk); #1;
        cmd_valid2 = 1'b0;
        cmd_dr2 = rnd38();
        cyc = 0;
        while (!rsp_valid2 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("fast_latency", 64'(cyc), 64'((3 + W + 1) * 2 * 1));
        chk("fast_tck_period", 64'(period2), 64'd20);
        chk("fast_rsp_dr", 64'(rsp_dr2), 64'(v.exp_rsp));
        chk("fast_slave_rx", 64'(s2_rx), 64'(v.exp_rx));
        @(negedge clk);
        rsp_ready2 = 1'b1;
        @(posedge clk); #1;
        rsp_ready2 = 1'b0;
        chk("fast_ack", 64'({rsp_valid2, cmd_ready2}), 64'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
